// File: rtl/alarm_buzzer_sequencer.sv
// Avalon-MM buzzer sequencer: square-wave tone gated by an on/off tick pattern, repeated N times or forever.
// Defining ALARM_BUZZER_IRQ_EN adds the irq port and the CTRL irq_enable bit; the default build has neither.
module alarm_buzzer_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int TONE_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef ALARM_BUZZER_IRQ_EN
  output logic        irq,
`endif
  output logic        out_port
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t            state_q, state_d;
  logic [TONE_W-1:0] tone_div_q, tone_div_d, sh_tone_q, sh_tone_d, tone_cnt_q, tone_cnt_d;
  logic [15:0]       on_ticks_q, on_ticks_d, off_ticks_q, off_ticks_d;
  logic [15:0]       sh_on_q, sh_on_d, sh_off_q, sh_off_d;
  logic [CNT_W-1:0]  repeat_q, repeat_d, sh_rep_q, sh_rep_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d, beeps_q, beeps_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tone_q, tone_d, done_q, done_d;
`ifdef ALARM_BUZZER_IRQ_EN
  logic              irq_en_q, irq_en_d, irq_q;
`endif

  logic              wr, start, stop, tick_end, phase_end;
  logic [15:0]       phase_ticks;
  logic [CNT_W-1:0]  beeps_inc;

  assign wr          = chipselect & ~write_n;
  assign start       = wr && (address == 2'd0) && writedata[0];
  assign stop        = wr && (address == 2'd0) && !writedata[0];
  assign tick_end    = (pre_q == PRE_LAST);
  assign phase_ticks = (state_q == S_ON) ? sh_on_q : sh_off_q;
  // Shadows are never 0, so the last tick of a phase is ticks-1
  assign phase_end   = tick_end && (tick_cnt_q == CNT_W'(phase_ticks - 16'd1));
  assign beeps_inc   = beeps_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    tone_div_d  = tone_div_q;
    on_ticks_d  = on_ticks_q;
    off_ticks_d = off_ticks_q;
    repeat_d    = repeat_q;
    sh_tone_d   = sh_tone_q;
    sh_on_d     = sh_on_q;
    sh_off_d    = sh_off_q;
    sh_rep_d    = sh_rep_q;
    tone_cnt_d  = tone_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    beeps_d     = beeps_q;
    pre_d       = pre_q;
    tone_d      = tone_q;
    done_d      = done_q;
`ifdef ALARM_BUZZER_IRQ_EN
    irq_en_d    = irq_en_q;
`endif

    if (wr) begin
      case (address)
        2'd1:    tone_div_d = writedata[TONE_W-1:0];
        2'd2:    {off_ticks_d, on_ticks_d} = writedata;
        2'd3:    repeat_d = writedata[CNT_W-1:0];
        default: begin
`ifdef ALARM_BUZZER_IRQ_EN
          irq_en_d = writedata[2];
          if (writedata[1]) done_d = 1'b0;
`endif
        end
      endcase
    end

    if (start) begin
      state_d    = S_ON;
      sh_tone_d  = (tone_div_q > TONE_W'(1)) ? tone_div_q : TONE_W'(1);
      sh_on_d    = (on_ticks_q == 16'd0) ? 16'd1 : on_ticks_q;
      sh_off_d   = (off_ticks_q == 16'd0) ? 16'd1 : off_ticks_q;
      sh_rep_d   = repeat_q;
      tone_cnt_d = '0;
      tick_cnt_d = '0;
      beeps_d    = '0;
      pre_d      = '0;
      tone_d     = 1'b0;
      done_d     = 1'b0;
    end else if (stop) begin
      state_d    = S_IDLE;
      tone_cnt_d = '0;
      tick_cnt_d = '0;
      pre_d      = '0;
      tone_d     = 1'b0;
    end else begin
      case (state_q)
        S_ON: begin
          if (tone_cnt_q == '0) begin
            tone_d     = ~tone_q;
            tone_cnt_d = sh_tone_q - TONE_W'(1);
          end else begin
            tone_cnt_d = tone_cnt_q - TONE_W'(1);
          end
          pre_d = tick_end ? '0 : pre_q + PRE_W'(1);
          if (tick_end) tick_cnt_d = tick_cnt_q + CNT_W'(1);
          if (phase_end) begin
            state_d    = S_OFF;
            tone_d     = 1'b0;
            tick_cnt_d = '0;
          end
        end
        S_OFF: begin
          pre_d = tick_end ? '0 : pre_q + PRE_W'(1);
          if (tick_end) tick_cnt_d = tick_cnt_q + CNT_W'(1);
          if (phase_end) begin
            tick_cnt_d = '0;
            beeps_d    = beeps_inc;
            tone_cnt_d = '0;
            // Repeat count 0 means run until stopped; beeps_done just wraps
            if ((sh_rep_q != '0) && (beeps_inc == sh_rep_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ON;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tone_div_q  <= '0;
      on_ticks_q  <= '0;
      off_ticks_q <= '0;
      repeat_q    <= '0;
      sh_tone_q   <= '0;
      sh_on_q     <= '0;
      sh_off_q    <= '0;
      sh_rep_q    <= '0;
      tone_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      beeps_q     <= '0;
      pre_q       <= '0;
      tone_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALARM_BUZZER_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tone_div_q  <= tone_div_d;
      on_ticks_q  <= on_ticks_d;
      off_ticks_q <= off_ticks_d;
      repeat_q    <= repeat_d;
      sh_tone_q   <= sh_tone_d;
      sh_on_q     <= sh_on_d;
      sh_off_q    <= sh_off_d;
      sh_rep_q    <= sh_rep_d;
      tone_cnt_q  <= tone_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      beeps_q     <= beeps_d;
      pre_q       <= pre_d;
      tone_q      <= tone_d;
      done_q      <= done_d;
`ifdef ALARM_BUZZER_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= done_q & irq_en_q;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0] = (state_q != S_IDLE);
        readdata[1] = done_q;
`ifdef ALARM_BUZZER_IRQ_EN
        readdata[2] = irq_en_q;
`endif
      end
      2'd1:    readdata[TONE_W-1:0] = tone_div_q;
      2'd2:    readdata = {off_ticks_q, on_ticks_q};
      default: readdata[CNT_W-1:0] = repeat_q;
    endcase
  end

  assign out_port = tone_q;
`ifdef ALARM_BUZZER_IRQ_EN
  assign irq = irq_q;
`endif

endmodule
